// File: rtl/roach_rst_seq_pkg.sv
// Shared types and helpers for the ROACH clock/reset sequencer.
package roach_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_MMCM_RST    = 3'd0,
      ST_WAIT_LOCK   = 3'd1,
      ST_LOCK_STABLE = 3'd2,
      ST_IDLY_RST    = 3'd3,
      ST_WAIT_RDY    = 3'd4,
      ST_RUN         = 3'd5,
      ST_FAULT       = 3'd7
   } seq_state_t;

   localparam logic [7:0] LOSS_COUNT_MAX = 8'hFF;

   // Width of the shared cycle counter: enough for the longest timed phase, plus one bit of headroom.
   function automatic int calc_cnt_width(input int a, input int b, input int c,
                                         input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/roach_clk_reset_sequencer_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
module roach_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic din,
   output logic dout
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   // Shift the async input down the flop chain; no reset so the flops can be packed together.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[STAGES-2:0], din};
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/roach_clk_reset_sequencer.sv
// Clock/reset bring-up sequencer running on the free-running EPB clock.
// Walks MMCM reset, lock qualification, IDELAYCTRL reset and ready wait,
// then releases the design reset and keeps watching lock and ready.
module roach_clk_reset_sequencer
   import roach_rst_seq_pkg::*;
#(
   parameter int MMCM_RST_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int IDELAY_RST_CYCLES   = 16,
   parameter int RDY_TIMEOUT_CYCLES  = 4096,
   parameter int MAX_RETRIES         = 3,
   parameter int USE_AUX_LOCK        = 1,
   parameter int SYNC_STAGES         = 2
) (
   input  logic       epb_clk,
   input  logic       epb_rst_n,
   input  logic       sys_clk_lock,
   input  logic       aux_clk_lock,
   input  logic       idelay_rdy,
   output logic       mmcm_rst,
   output logic       idelay_rst,
   output logic       sys_rst,
   output logic       seq_done,
   output logic       seq_fault,
   output logic [2:0] seq_state,
   output logic [1:0] retry_count,
   output logic [7:0] lock_loss_count
);

   localparam int CNT_W = calc_cnt_width(MMCM_RST_CYCLES, LOCK_STABLE_CYCLES,
                                         LOCK_TIMEOUT_CYCLES, IDELAY_RST_CYCLES,
                                         RDY_TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLY_LAST    = CNT_W'(IDELAY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] RDY_TO_LAST  = CNT_W'(RDY_TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);
   localparam logic             AUX_IGNORED  = (USE_AUX_LOCK == 0);

   seq_state_t       state_q, state_d, retry_tgt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             retry_req;
   logic             sys_lock_s, aux_lock_s, rdy;
   logic             lk;
   logic             mmcm_rst_d, idelay_rst_d, sys_rst_d, seq_done_d, seq_fault_d;

   roach_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sys (
      .clk  (epb_clk),
      .din  (sys_clk_lock),
      .dout (sys_lock_s)
   );

   roach_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_aux (
      .clk  (epb_clk),
      .din  (aux_clk_lock),
      .dout (aux_lock_s)
   );

   roach_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdy (
      .clk  (epb_clk),
      .din  (idelay_rdy),
      .dout (rdy)
   );

   assign lk = sys_lock_s & (aux_lock_s | AUX_IGNORED);

   // Next-state logic: phase transitions, retry accounting and loss counting.
   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      loss_d    = loss_q;
      retry_req = 1'b0;
      retry_tgt = ST_MMCM_RST;
      case (state_q)
         ST_MMCM_RST: begin
            if (cnt_q == MMCM_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lk)                         state_d   = ST_LOCK_STABLE;
            else if (cnt_q == LOCK_TO_LAST) retry_req = 1'b1;
         end
         ST_LOCK_STABLE: begin
            if (!lk)                       state_d = ST_WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = ST_IDLY_RST;
         end
         ST_IDLY_RST: begin
            if (cnt_q == IDLY_LAST) state_d = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            // Lock loss wins over ready so the design never starts on an unlocked clock.
            if (!lk) begin
               retry_req = 1'b1;
            end else if (rdy) begin
               state_d = ST_RUN;
               retry_d = '0;
            end else if (cnt_q == RDY_TO_LAST) begin
               retry_req = 1'b1;
               retry_tgt = ST_IDLY_RST;
            end
         end
         ST_RUN: begin
            if (!lk || !rdy) begin
               state_d = lk ? ST_IDLY_RST : ST_MMCM_RST;
               if (loss_q != LOSS_COUNT_MAX) loss_d = loss_q + 8'd1;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_MMCM_RST;
         end
      endcase
      if (retry_req) begin
         if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAULT;
         end else begin
            retry_d = retry_q + 2'd1;
            state_d = retry_tgt;
         end
      end
   end

   // Shared cycle counter: cleared on any state change, idle in RUN and FAULT.
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q) begin
         case (state_q)
            ST_MMCM_RST, ST_WAIT_LOCK, ST_LOCK_STABLE,
            ST_IDLY_RST, ST_WAIT_RDY: cnt_d = cnt_q + CNT_W'(1);
            default:                  cnt_d = '0;
         endcase
      end
   end

   // Output decode from the next state so outputs move together with seq_state.
   always_comb begin
      mmcm_rst_d   = (state_d == ST_MMCM_RST);
      idelay_rst_d = (state_d == ST_MMCM_RST) || (state_d == ST_WAIT_LOCK) ||
                     (state_d == ST_LOCK_STABLE) || (state_d == ST_IDLY_RST);
      sys_rst_d    = (state_d != ST_RUN);
      seq_done_d   = (state_d == ST_RUN);
      seq_fault_d  = (state_d == ST_FAULT);
   end

   // State, counters and registered outputs with synchronous active-low reset.
   always_ff @(posedge epb_clk) begin
      if (!epb_rst_n) begin
         state_q    <= ST_MMCM_RST;
         cnt_q      <= '0;
         retry_q    <= '0;
         loss_q     <= '0;
         mmcm_rst   <= 1'b1;
         idelay_rst <= 1'b1;
         sys_rst    <= 1'b1;
         seq_done   <= 1'b0;
         seq_fault  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         loss_q     <= loss_d;
         mmcm_rst   <= mmcm_rst_d;
         idelay_rst <= idelay_rst_d;
         sys_rst    <= sys_rst_d;
         seq_done   <= seq_done_d;
         seq_fault  <= seq_fault_d;
      end
   end

   assign seq_state       = state_q;
   assign retry_count     = retry_q;
   assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_roach_clk_reset_sequencer.sv
// Self-checking bench for roach_clk_reset_sequencer: a cycle model of the
// bring-up rules checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_roach_clk_reset_sequencer;

   localparam int P_MMCM    = 4;
   localparam int P_STABLE  = 8;
   localparam int P_LTO     = 32;
   localparam int P_IDLY    = 4;
   localparam int P_RTO     = 32;
   localparam int P_RETRIES = 3;
   localparam int P_SYNC    = 2;

   logic       epb_clk      = 1'b0;
   logic       epb_rst_n    = 1'b0;
   logic       sys_clk_lock = 1'b1;
   logic       aux_clk_lock = 1'b1;
   logic       idelay_rdy   = 1'b0;

   logic       mmcmRst, idelayRst, sysRst, seqDone, seqFault;
   logic [2:0] seqState;
   logic [1:0] retryCount;
   logic [7:0] lossCount;

   logic       naMmcmRst, naIdelayRst, naSysRst, naSeqDone, naSeqFault;
   logic [2:0] naSeqState;
   logic [1:0] naRetryCount;
   logic [7:0] naLossCount;

   int checks = 0;
   int errors = 0;

   roach_clk_reset_sequencer #(
      .MMCM_RST_CYCLES(P_MMCM), .LOCK_STABLE_CYCLES(P_STABLE), .LOCK_TIMEOUT_CYCLES(P_LTO),
      .IDELAY_RST_CYCLES(P_IDLY), .RDY_TIMEOUT_CYCLES(P_RTO), .MAX_RETRIES(P_RETRIES),
      .USE_AUX_LOCK(1), .SYNC_STAGES(P_SYNC)
   ) dut (
      .epb_clk(epb_clk), .epb_rst_n(epb_rst_n), .sys_clk_lock(sys_clk_lock),
      .aux_clk_lock(aux_clk_lock), .idelay_rdy(idelay_rdy), .mmcm_rst(mmcmRst),
      .idelay_rst(idelayRst), .sys_rst(sysRst), .seq_done(seqDone), .seq_fault(seqFault),
      .seq_state(seqState), .retry_count(retryCount), .lock_loss_count(lossCount)
   );

   roach_clk_reset_sequencer #(
      .MMCM_RST_CYCLES(P_MMCM), .LOCK_STABLE_CYCLES(P_STABLE), .LOCK_TIMEOUT_CYCLES(P_LTO),
      .IDELAY_RST_CYCLES(P_IDLY), .RDY_TIMEOUT_CYCLES(P_RTO), .MAX_RETRIES(P_RETRIES),
      .USE_AUX_LOCK(0), .SYNC_STAGES(P_SYNC)
   ) dutNoAux (
      .epb_clk(epb_clk), .epb_rst_n(epb_rst_n), .sys_clk_lock(sys_clk_lock),
      .aux_clk_lock(aux_clk_lock), .idelay_rdy(idelay_rdy), .mmcm_rst(naMmcmRst),
      .idelay_rst(naIdelayRst), .sys_rst(naSysRst), .seq_done(naSeqDone), .seq_fault(naSeqFault),
      .seq_state(naSeqState), .retry_count(naRetryCount), .lock_loss_count(naLossCount)
   );

   // Free-running EPB clock, 10 ns period.
   always #5 epb_clk = ~epb_clk;

   // One comparison: bump the check count, report and count any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic r, input logic rn);
      sys_clk_lock = s;
      aux_clk_lock = a;
      idelay_rdy   = r;
      epb_rst_n    = rn;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge epb_clk);
   endtask

   task automatic waitState(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (seqState !== 3'(target) && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput(name, 32'(seqState), 32'(target));
   endtask

   task automatic countState(input int st, input int budget, output int n);
      n = 0;
      while (seqState === 3'(st) && n < budget) begin
         n++;
         tick(1);
      end
   endtask

   // Reference model: phase and time-in-phase, inputs delayed through a queue per status line.
   int  mState = 0;
   int  mCnt   = 0;
   int  mRetry = 0;
   int  mLoss  = 0;
   bit  modelValid = 0;
   bit  qSys[$];
   bit  qAux[$];
   bit  qRdy[$];

   initial begin
      for (int i = 0; i < P_SYNC; i++) begin
         qSys.push_back(1'b0);
         qAux.push_back(1'b0);
         qRdy.push_back(1'b0);
      end
   end

   // Advance the model by one EPB clock using the sequencing rules.
   always @(posedge epb_clk) begin
      bit lkM, rdyM, sysS, auxS, doRetry;
      int nxt, tgt;
      sysS = qSys.pop_front();
      auxS = qAux.pop_front();
      rdyM = qRdy.pop_front();
      qSys.push_back(sys_clk_lock);
      qAux.push_back(aux_clk_lock);
      qRdy.push_back(idelay_rdy);
      lkM = sysS && auxS;
      if (!epb_rst_n) begin
         mState = 0;
         mCnt = 0;
         mRetry = 0;
         mLoss = 0;
         modelValid = 1;
      end else begin
         nxt = mState;
         doRetry = 0;
         tgt = 0;
         if (mState == 0) begin
            if (mCnt + 1 >= P_MMCM) nxt = 1;
         end else if (mState == 1) begin
            if (lkM) nxt = 2;
            else if (mCnt + 1 >= P_LTO) doRetry = 1;
         end else if (mState == 2) begin
            if (!lkM) nxt = 1;
            else if (mCnt + 1 >= P_STABLE) nxt = 3;
         end else if (mState == 3) begin
            if (mCnt + 1 >= P_IDLY) nxt = 4;
         end else if (mState == 4) begin
            if (!lkM) doRetry = 1;
            else if (rdyM) begin
               nxt = 5;
               mRetry = 0;
            end else if (mCnt + 1 >= P_RTO) begin
               doRetry = 1;
               tgt = 3;
            end
         end else if (mState == 5) begin
            if (!lkM || !rdyM) begin
               nxt = lkM ? 3 : 0;
               mLoss = (mLoss >= 255) ? 255 : mLoss + 1;
            end
         end
         if (doRetry) begin
            if (mRetry >= P_RETRIES) nxt = 7;
            else begin
               mRetry++;
               nxt = tgt;
            end
         end
         mCnt = (nxt != mState) ? 0 : mCnt + 1;
         mState = nxt;
      end
   end

   // Compare every DUT output with the model on each falling edge once reset has been seen.
   always @(negedge epb_clk) begin
      if (modelValid) begin
         checkOutput("m_state",      32'(seqState),   32'(mState));
         checkOutput("m_mmcm_rst",   32'(mmcmRst),    32'(mState == 0));
         checkOutput("m_idelay_rst", 32'(idelayRst),  32'(mState <= 3));
         checkOutput("m_sys_rst",    32'(sysRst),     32'(mState != 5));
         checkOutput("m_seq_done",   32'(seqDone),    32'(mState == 5));
         checkOutput("m_seq_fault",  32'(seqFault),   32'(mState == 7));
         checkOutput("m_retry",      32'(retryCount), 32'(mRetry));
         checkOutput("m_loss",       32'(lossCount),  32'(mLoss));
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios with hand-computed expectations.
   initial begin
      int n, cyc, hiLen, loLen, pulses, gaps, lensBad, gapsBad;

      // Reset state
      applyStimulus(1, 1, 0, 0);
      tick(4);
      checkOutput("rst_state",   32'(seqState),   0);
      checkOutput("rst_mmcm",    32'(mmcmRst),    1);
      checkOutput("rst_idly",    32'(idelayRst),  1);
      checkOutput("rst_sys",     32'(sysRst),     1);
      checkOutput("rst_done",    32'(seqDone),    0);
      checkOutput("rst_fault",   32'(seqFault),   0);
      checkOutput("rst_retry",   32'(retryCount), 0);
      checkOutput("rst_loss",    32'(lossCount),  0);
      checkOutput("na_rst_state", 32'({naSeqState, naMmcmRst, naIdelayRst, naSysRst,
                                        naSeqDone, naSeqFault, naRetryCount, naLossCount}),
                  32'({3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}));

      // 1. Nominal bring-up
      $display("[TB] nominal");
      applyStimulus(1, 1, 0, 1);
      n = 0;
      while (mmcmRst === 1'b1 && n < 20) begin
         n++;
         tick(1);
      end
      checkOutput("t1_mmcm_len", n, 4);
      waitState(3, 40, "t1_reach_idly");
      countState(3, 20, n);
      checkOutput("t1_idly_len", n, 4);
      checkOutput("t1_wait_rdy", 32'(seqState), 4);
      checkOutput("t1_idly_low", 32'(idelayRst), 0);
      applyStimulus(1, 1, 1, 1);
      waitState(5, 10, "t1_run");
      checkOutput("t1_sys_rst", 32'(sysRst), 0);
      checkOutput("t1_done", 32'(seqDone), 1);
      checkOutput("t1_retry", 32'(retryCount), 0);

      // 2. One-cycle lock glitch inside the stable window
      $display("[TB] lock glitch");
      applyStimulus(1, 1, 1, 0);
      tick(1);
      applyStimulus(1, 1, 1, 1);
      waitState(2, 20, "t2_stable");
      tick(4);
      applyStimulus(0, 1, 1, 1);
      tick(1);
      applyStimulus(1, 1, 1, 1);
      waitState(1, 10, "t2_back_wait_lock");
      waitState(2, 10, "t2_stable_again");
      countState(2, 20, n);
      checkOutput("t2_stable_len", n, 8);
      checkOutput("t2_idly_next", 32'(seqState), 3);
      waitState(5, 40, "t2_run");

      // 3. Never lock: four MMCM pulses, then fault
      $display("[TB] never lock");
      applyStimulus(0, 1, 1, 0);
      tick(1);
      applyStimulus(0, 1, 1, 1);
      cyc = 0; hiLen = 0; loLen = 0; pulses = 0; gaps = 0; lensBad = 0; gapsBad = 0;
      while (seqState !== 3'd7 && cyc < 400) begin
         if (mmcmRst === 1'b1) begin
            if (loLen > 0) begin
               gaps++;
               if (loLen != 32) gapsBad++;
               loLen = 0;
            end
            hiLen++;
         end else begin
            if (hiLen > 0) begin
               pulses++;
               if (hiLen != 4) lensBad++;
               hiLen = 0;
            end
            loLen++;
         end
         tick(1);
         cyc++;
      end
      checkOutput("t3_pulses", pulses, 4);
      checkOutput("t3_bad_pulse_len", lensBad, 0);
      checkOutput("t3_gaps", gaps, 3);
      checkOutput("t3_bad_gap_len", gapsBad, 0);
      checkOutput("t3_state", 32'(seqState), 7);
      checkOutput("t3_fault", 32'(seqFault), 1);
      checkOutput("t3_sys_rst", 32'(sysRst), 1);
      checkOutput("t3_mmcm", 32'(mmcmRst), 0);
      checkOutput("t3_retry", 32'(retryCount), 3);
      applyStimulus(1, 1, 1, 1);
      tick(5);
      checkOutput("t3_sticky", 32'(seqState), 7);
      applyStimulus(1, 1, 1, 0);
      tick(1);
      checkOutput("t3_fault_clr", 32'(seqFault), 0);
      checkOutput("t3_state_clr", 32'(seqState), 0);
      applyStimulus(1, 1, 1, 1);
      waitState(5, 60, "t3_run");

      // 4. Aux lock loss in RUN
      $display("[TB] aux lock loss");
      checkOutput("t4_loss0", 32'(lossCount), 0);
      checkOutput("t4_na_run0", 32'(naSeqState), 5);
      applyStimulus(1, 0, 1, 1);
      tick(2);
      checkOutput("t4_sys_rst_pre", 32'(sysRst), 0);
      tick(1);
      checkOutput("t4_sys_rst", 32'(sysRst), 1);
      checkOutput("t4_loss1", 32'(lossCount), 1);
      checkOutput("t4_state", 32'(seqState), 0);
      checkOutput("t4_na_run", 32'(naSeqState), 5);
      checkOutput("t4_na_sys", 32'(naSysRst), 0);
      applyStimulus(1, 1, 1, 1);
      waitState(5, 60, "t4_run");
      checkOutput("t4_loss_keep", 32'(lossCount), 1);
      checkOutput("t4_na_still", 32'(naSeqState), 5);
      checkOutput("t4_na_loss", 32'(naLossCount), 0);

      // 5. Ready-only loss, then simultaneous loss
      $display("[TB] ready loss");
      applyStimulus(1, 1, 0, 1);
      tick(2);
      applyStimulus(1, 1, 1, 1);
      tick(1);
      checkOutput("t5_idly", 32'(seqState), 3);
      checkOutput("t5_mmcm", 32'(mmcmRst), 0);
      countState(3, 20, n);
      checkOutput("t5_idly_len", n, 4);
      checkOutput("t5_loss2", 32'(lossCount), 2);
      waitState(5, 20, "t5_run");
      applyStimulus(0, 1, 0, 1);
      tick(3);
      checkOutput("t5_both_state", 32'(seqState), 0);
      checkOutput("t5_loss3", 32'(lossCount), 3);
      applyStimulus(1, 1, 1, 1);
      waitState(5, 80, "t5_run2");
      checkOutput("t5_loss3_keep", 32'(lossCount), 3);

      // 6. Saturation, ready timeout retry, reset mid WAIT_RDY
      $display("[TB] saturation");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 1, 1, 1);
         tick(3);
         applyStimulus(1, 1, 1, 1);
         waitState(5, 80, "t6_rerun");
      end
      checkOutput("t6_loss_sat", 32'(lossCount), 255);
      applyStimulus(1, 1, 0, 1);
      waitState(4, 20, "t6_wait_rdy");
      waitState(3, 50, "t6_rdy_timeout");
      checkOutput("t6_retry1", 32'(retryCount), 1);
      checkOutput("t6_loss_hold", 32'(lossCount), 255);
      waitState(4, 20, "t6_wait_rdy2");
      tick(2);
      applyStimulus(1, 1, 0, 0);
      tick(1);
      applyStimulus(1, 1, 0, 1);
      checkOutput("t6_rst_state", 32'(seqState),   0);
      checkOutput("t6_rst_mmcm",  32'(mmcmRst),    1);
      checkOutput("t6_rst_idly",  32'(idelayRst),  1);
      checkOutput("t6_rst_sys",   32'(sysRst),     1);
      checkOutput("t6_rst_done",  32'(seqDone),    0);
      checkOutput("t6_rst_fault", 32'(seqFault),   0);
      checkOutput("t6_rst_retry", 32'(retryCount), 0);
      checkOutput("t6_rst_loss",  32'(lossCount),  0);
      tick(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
